pkt_task_sched: RTL and testbench



---
 rtl/pkt_gen_pkg.sv | 23 ++
 rtl/pkt_task_sched_arb.sv | 54 +++++
 rtl/pkt_task_sched.sv | 156 +++++++++++++++
 tb/tb_pkt_task_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pkt_gen_pkg.sv
// Shared types and constants for the packet generator and its task scheduler.
// Holds the per-flow configuration record layout and the scheduler FSM encoding.
package pkt_gen_pkg;

  localparam int FLOW_CNT_DEF   = 16;
  localparam int CNT_WIDTH_DEF  = 32;
  localparam int PKT_SIZE_WIDTH = 16;
  localparam int MOD_WIDTH      = 3;

  typedef struct packed {
    logic [PKT_SIZE_WIDTH-1:0] size;
    logic [CNT_WIDTH_DEF-1:0]  remaining;
    logic                      unlimited;
    logic                      enabled;
  } flow_cfg_t;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    RUN_S   = 2'd1,
    DRAIN_S = 2'd2
  } sched_state_t;

endpackage

// File: rtl/pkt_task_sched_arb.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps,
// returning a one-hot grant, its index and an any-grant flag.
module rr_arbiter #(
  parameter int FLOW_CNT       = 16,
  parameter int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT)
) (
  input  logic [FLOW_CNT-1:0]       req_i,
  input  logic [FLOW_CNT_WIDTH-1:0] ptr_i,
  output logic [FLOW_CNT-1:0]       grant_o,
  output logic [FLOW_CNT_WIDTH-1:0] grant_idx_o,
  output logic                      any_grant_o
);

  localparam int SUM_W = FLOW_CNT_WIDTH + 1;

  logic [SUM_W-1:0]          w_cand;
  logic [FLOW_CNT_WIDTH-1:0] w_idx;
  logic                      w_found;

  // Walk candidates ptr, ptr+1, ... modulo FLOW_CNT; the first requester wins.
  always_comb begin
    w_cand  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < FLOW_CNT; i++) begin
      w_cand = {1'b0, ptr_i} + SUM_W'(i);
      if (w_cand >= SUM_W'(FLOW_CNT)) begin
        w_cand = w_cand - SUM_W'(FLOW_CNT);
      end else begin
        w_cand = w_cand;
      end
      if (!w_found && req_i[w_cand[FLOW_CNT_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_cand[FLOW_CNT_WIDTH-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // Expand the winning index into a one-hot grant vector.
  always_comb begin
    grant_o = '0;
    if (w_found) begin
      grant_o[w_idx] = 1'b1;
    end else begin
      grant_o = '0;
    end
  end

  assign grant_idx_o = w_idx;
  assign any_grant_o = w_found;

endmodule

// File: rtl/pkt_task_sched.sv
// Multi-flow task scheduler feeding the packet generator: per-flow size/count
// configuration, round-robin selection and a single show-ahead task register.
module pkt_task_sched
  import pkt_gen_pkg::*;
#(
  parameter int FLOW_CNT       = FLOW_CNT_DEF,
  parameter int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT),
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      run_i,
  input  logic                      cfg_wr_i,
  input  logic [FLOW_CNT_WIDTH-1:0] cfg_flow_i,
  input  logic [PKT_SIZE_WIDTH-1:0] cfg_size_i,
  input  logic [CNT_WIDTH-1:0]      cfg_pkt_cnt_i,
  output logic [FLOW_CNT_WIDTH-1:0] pkt_task_str_o,
  output logic [PKT_SIZE_WIDTH-1:0] pkt_task_size_o,
  output logic                      pkt_task_val_o,
  input  logic                      pkt_task_rd_req_i,
  output logic [FLOW_CNT-1:0]       flow_active_o,
  output logic                      done_o
);

  logic [PKT_SIZE_WIDTH-1:0] r_size      [FLOW_CNT];
  logic [CNT_WIDTH-1:0]      r_remaining [FLOW_CNT];
  logic [FLOW_CNT-1:0]       r_unlimited;
  logic [FLOW_CNT-1:0]       r_enabled;

  logic [FLOW_CNT_WIDTH-1:0] r_ptr;
  logic [FLOW_CNT_WIDTH-1:0] r_task_str;
  logic [PKT_SIZE_WIDTH-1:0] r_task_size;
  logic                      r_task_val;

  sched_state_t r_state;
  sched_state_t w_state_nxt;

  logic [FLOW_CNT-1:0]       w_eligible;
  logic [FLOW_CNT-1:0]       w_grant;
  logic [FLOW_CNT_WIDTH-1:0] w_grant_idx;
  logic                      w_any;
  logic                      w_load;

  // A flow is eligible while enabled and it still has packets left to send.
  always_comb begin
    w_eligible = '0;
    for (int f = 0; f < FLOW_CNT; f++) begin
      w_eligible[f] = r_enabled[f] & (r_unlimited[f] | (r_remaining[f] != '0));
    end
  end

  rr_arbiter #(
    .FLOW_CNT       (FLOW_CNT),
    .FLOW_CNT_WIDTH (FLOW_CNT_WIDTH)
  ) u_arb (
    .req_i       (w_eligible),
    .ptr_i       (r_ptr),
    .grant_o     (w_grant),
    .grant_idx_o (w_grant_idx),
    .any_grant_o (w_any)
  );

  assign w_load = run_i & (~r_task_val | pkt_task_rd_req_i) & w_any;

  // Per-flow configuration; a same-cycle write overrides the load decrement.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int f = 0; f < FLOW_CNT; f++) begin
        r_size[f]      <= '0;
        r_remaining[f] <= '0;
      end
      r_unlimited <= '0;
      r_enabled   <= '0;
    end else begin
      for (int f = 0; f < FLOW_CNT; f++) begin
        if (cfg_wr_i && (cfg_flow_i == FLOW_CNT_WIDTH'(f))) begin
          r_size[f]      <= cfg_size_i;
          r_remaining[f] <= cfg_pkt_cnt_i;
          r_unlimited[f] <= (cfg_pkt_cnt_i == '0);
          r_enabled[f]   <= (cfg_size_i != '0);
        end else if (w_load && w_grant[f] && !r_unlimited[f]) begin
          r_remaining[f] <= r_remaining[f] - CNT_WIDTH'(1);
        end
      end
    end
  end

  // Task register and round-robin pointer; the task captures the pre-write size.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_task_str  <= '0;
      r_task_size <= '0;
      r_task_val  <= 1'b0;
      r_ptr       <= '0;
    end else if (w_load) begin
      r_task_str  <= w_grant_idx;
      r_task_size <= r_size[w_grant_idx];
      r_task_val  <= 1'b1;
      r_ptr       <= (w_grant_idx == FLOW_CNT_WIDTH'(FLOW_CNT - 1)) ?
                     '0 : (w_grant_idx + FLOW_CNT_WIDTH'(1));
    end else if (pkt_task_rd_req_i && r_task_val) begin
      r_task_val  <= 1'b0;
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE_S;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: DRAIN keeps a held task until it is popped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE_S: begin
        if (run_i) begin
          w_state_nxt = RUN_S;
        end else begin
          w_state_nxt = IDLE_S;
        end
      end
      RUN_S: begin
        if (run_i) begin
          w_state_nxt = RUN_S;
        end else if (r_task_val) begin
          w_state_nxt = DRAIN_S;
        end else begin
          w_state_nxt = IDLE_S;
        end
      end
      DRAIN_S: begin
        if (run_i) begin
          w_state_nxt = RUN_S;
        end else if (!r_task_val || pkt_task_rd_req_i) begin
          w_state_nxt = IDLE_S;
        end else begin
          w_state_nxt = DRAIN_S;
        end
      end
      default: begin
        w_state_nxt = IDLE_S;
      end
    endcase
  end

  assign pkt_task_str_o  = r_task_str;
  assign pkt_task_size_o = r_task_size;
  assign pkt_task_val_o  = r_task_val;
  assign flow_active_o   = w_eligible;
  assign done_o          = run_i & ~(|w_eligible) & ~r_task_val;

endmodule

// File: tb/tb_pkt_task_sched.sv
// Directed bench for pkt_task_sched: inputs change on the falling edge and
// outputs are compared there against hand-computed values.
module tb_pkt_task_sched;
  import pkt_gen_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        cfg_wr;
  logic [3:0]  cfg_flow;
  logic [15:0] cfg_size;
  logic [31:0] cfg_cnt;
  logic [3:0]  task_str;
  logic [15:0] task_size;
  logic        task_val;
  logic        rd_req;
  logic [15:0] active;
  logic        done;

  int checks = 0;
  int errors = 0;

  pkt_task_sched dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .run_i             (run),
    .cfg_wr_i          (cfg_wr),
    .cfg_flow_i        (cfg_flow),
    .cfg_size_i        (cfg_size),
    .cfg_pkt_cnt_i     (cfg_cnt),
    .pkt_task_str_o    (task_str),
    .pkt_task_size_o   (task_size),
    .pkt_task_val_o    (task_val),
    .pkt_task_rd_req_i (rd_req),
    .flow_active_o     (active),
    .done_o            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [3:0] f, input logic [15:0] s, input logic [31:0] c);
    cfg_wr   = 1'b1;
    cfg_flow = f;
    cfg_size = s;
    cfg_cnt  = c;
  endtask

  task automatic chk_task(input string tag, input logic [3:0] f, input logic [15:0] s);
    chk(tag, {11'd0, task_val, task_str, task_size}, {11'd0, 1'b1, f, s});
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; cfg_wr = 1'b0; cfg_flow = 4'd0;
    cfg_size = 16'd0; cfg_cnt = 32'd0; rd_req = 1'b0;
    @(negedge clk);
    chk("rst_val", 32'(task_val), 32'd0);
    chk("rst_str", 32'(task_str), 32'd0);
    chk("rst_size", 32'(task_size), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE_S));
    rst_n = 1'b1;
    tick();

    // single finite flow: 3 tasks {3,64}
    cfg(4'd3, 16'd64, 32'd3);
    tick();
    cfg_wr = 1'b0;
    chk("fin_active", 32'(active), 32'h0008);
    chk("fin_val0", 32'(task_val), 32'd0);
    run = 1'b1; rd_req = 1'b1;
    tick();
    chk_task("fin_t1", 4'd3, 16'd64);
    chk("fin_rem2", dut.r_remaining[3], 32'd2);
    tick();
    chk_task("fin_t2", 4'd3, 16'd64);
    tick();
    chk_task("fin_t3", 4'd3, 16'd64);
    chk("fin_active0", 32'(active), 32'd0);
    tick();
    chk("fin_val_off", 32'(task_val), 32'd0);
    chk("fin_done", 32'(done), 32'd1);

    // round-robin over unlimited flows 0/5/15, pointer sits at 4
    run = 1'b0; rd_req = 1'b0;
    tick();
    chk("rr_idle", 32'(dut.r_state), 32'(IDLE_S));
    cfg(4'd0, 16'd60, 32'd0);   tick();
    cfg(4'd5, 16'd128, 32'd0);  tick();
    cfg(4'd15, 16'd1500, 32'd0); tick();
    cfg_wr = 1'b0;
    chk("rr_active", 32'(active), 32'h8021);
    run = 1'b1; rd_req = 1'b1;
    tick(); chk_task("rr_a5", 4'd5, 16'd128);
    tick(); chk_task("rr_a15", 4'd15, 16'd1500);
    tick(); chk_task("rr_a0", 4'd0, 16'd60);
    tick(); chk_task("rr_b5", 4'd5, 16'd128);
    tick(); chk_task("rr_b15", 4'd15, 16'd1500);
    tick(); chk_task("rr_b0", 4'd0, 16'd60);

    // back-pressure then drain
    rd_req = 1'b0; run = 1'b0;
    tick();
    chk("bp_drain", 32'(dut.r_state), 32'(DRAIN_S));
    for (int i = 0; i < 10; i++) begin
      chk_task("bp_hold", 4'd0, 16'd60);
      tick();
    end
    chk_task("bp_hold_end", 4'd0, 16'd60);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("bp_val0", 32'(task_val), 32'd0);
    chk("bp_idle", 32'(dut.r_state), 32'(IDLE_S));
    chk("bp_active", 32'(active), 32'h8021);
    chk("bp_rem3", dut.r_remaining[3], 32'd0);

    // disable an active flow while its task is held
    cfg(4'd2, 16'd200, 32'd10);
    tick();
    cfg_wr = 1'b0;
    chk("dis_active", 32'(active), 32'h8025);
    run = 1'b1;
    tick();
    chk_task("dis_t2", 4'd2, 16'd200);
    chk("dis_rem9", dut.r_remaining[2], 32'd9);
    cfg(4'd2, 16'd0, 32'd10);
    tick();
    cfg_wr = 1'b0;
    chk("dis_active2", 32'(active), 32'h8021);
    chk_task("dis_held", 4'd2, 16'd200);
    rd_req = 1'b1;
    tick(); chk_task("dis_g5", 4'd5, 16'd128);
    tick(); chk_task("dis_g15", 4'd15, 16'd1500);
    tick(); chk_task("dis_g0", 4'd0, 16'd60);
    tick(); chk_task("dis_g5b", 4'd5, 16'd128);

    // collision: write cnt=7 to flow 15 in the cycle it is loaded
    cfg(4'd15, 16'd100, 32'd7);
    tick();
    cfg_wr = 1'b0;
    chk_task("col_pre_size", 4'd15, 16'd1500);
    chk("col_rem7", dut.r_remaining[15], 32'd7);
    tick(); chk_task("col_g0", 4'd0, 16'd60);
    tick(); chk_task("col_g5", 4'd5, 16'd128);
    tick(); chk_task("col_g15", 4'd15, 16'd100);
    chk("col_rem6", dut.r_remaining[15], 32'd6);
    rd_req = 1'b0;

    // reset mid-operation
    rst_n = 1'b0;
    #1;
    chk("mrst_val", 32'(task_val), 32'd0);
    chk("mrst_active", 32'(active), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_idle", 32'(dut.r_state), 32'(IDLE_S));
    rd_req = 1'b1;
    tick();
    chk("mrst_noval", 32'(task_val), 32'd0);
    chk("mrst_done", 32'(done), 32'd1);
    tick();
    chk("mrst_noval2", 32'(task_val), 32'd0);
    rd_req = 1'b0;
    cfg(4'd7, 16'd32, 32'd1);
    tick();
    cfg_wr = 1'b0;
    chk("mrst_active7", 32'(active), 32'h0080);
    chk("mrst_val_n1", 32'(task_val), 32'd0);
    tick();
    chk_task("mrst_t7", 4'd7, 16'd32);
    rd_req = 1'b1;
    tick();
    chk("mrst_val_end", 32'(task_val), 32'd0);
    chk("mrst_done_end", 32'(done), 32'd1);
    rd_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
